// File: rtl/shift_pkg.sv
// Shared types and constants for the RV32I shift execute pipeline.
// Holds the shift-type encoding, the opcode/funct constants, the stage-A payload
// layout and the combinational shifter used between stage A and stage B.
package shift_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    LL   = 2'b00,
    LR   = 2'b01,
    AR   = 2'b10,
    NONE = 2'b11
  } shift_type_e;

  // Everything stage A needs to drive the shifter and tag the result.
  typedef struct packed {
    logic [XLEN-1:0]  rs1;
    logic [4:0]       shamt;
    shift_type_e      stype;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } stage_a_t;

  // Combinational barrel shifter; NONE yields zero so illegal ops carry a clean result.
  function automatic logic [XLEN-1:0] shift_apply(input logic [XLEN-1:0] value,
                                                  input logic [4:0]      shamt,
                                                  input shift_type_e     stype);
    logic [XLEN-1:0] res;
    res = '0;
    case (stype)
      LL:      res = value << shamt;
      LR:      res = value >> shamt;
      AR:      res = $signed(value) >>> shamt;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of opcode/funct3/funct7 into shift type, shift amount and
// an illegal-encoding flag.
// Build option: SHIFT_EXEC_ILLEGAL_CHECK_EN -- when defined, funct7 is fully
// checked and anything that is not an exact shift encoding raises illegal.
// When undefined, only funct7[5] is looked at (AR vs LR) and illegal stays 0.
module shift_decode
  import shift_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs2_lo,
  input  logic [4:0]  imm,
  output shift_type_e stype,
  output logic [4:0]  shamt,
  output logic        illegal
);

  logic is_op;
  logic is_op_imm;

  assign is_op     = (opcode == OPC_OP);
  assign is_op_imm = (opcode == OPC_OP_IMM);

`ifndef SHIFT_EXEC_ILLEGAL_CHECK_EN
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};
`endif

  // Map the instruction fields onto a shift type; anything unrecognised becomes NONE.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    stype   = NONE;
    shamt   = is_op_imm ? imm : rs2_lo;
    illegal = 1'b0;
    if (is_op || is_op_imm) begin
`ifdef SHIFT_EXEC_ILLEGAL_CHECK_EN
      if (funct3 == F3_SLL && funct7 == F7_BASE)      stype = LL;
      else if (funct3 == F3_SRX && funct7 == F7_BASE) stype = LR;
      else if (funct3 == F3_SRX && funct7 == F7_ALT)  stype = AR;
`else
      if (funct3 == F3_SLL)      stype = LL;
      else if (funct3 == F3_SRX) stype = funct7[5] ? AR : LR;
`endif
    end
`ifdef SHIFT_EXEC_ILLEGAL_CHECK_EN
    illegal = (stype == NONE);
`endif
  end

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage execute wrapper for RV32I shifts: decode + issue register (stage A),
// shifter, result register (stage B), with bubble-collapsing valid/ready on both
// sides and a destination tag carried through to writeback.
// Build option: SHIFT_EXEC_ILLEGAL_CHECK_EN enables illegal-encoding reporting
// on out_err; without it out_err is always 0.
module shift_exec_pipe
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [4:0]       in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  shift_type_e      dec_type;
  logic [4:0]       dec_shamt;
  logic             dec_illegal;
  stage_a_t         a_d;
  stage_a_t         a_q;
  logic             a_valid;
  logic             b_valid;
  logic [XLEN-1:0]  b_result;
  logic [TAG_W-1:0] b_tag;
  logic             b_err;
  logic             b_free;
  logic             a_adv;
  logic             accept;
  logic [XLEN-1:0]  shift_result;

  // Only the low five bits of rs2 form the shift amount.
  logic unused_rs2;
  assign unused_rs2 = ^in_rs2[XLEN-1:5];

  shift_decode u_decode (
    .opcode  (in_opcode),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .rs2_lo  (in_rs2[4:0]),
    .imm     (in_imm),
    .stype   (dec_type),
    .shamt   (dec_shamt),
    .illegal (dec_illegal)
  );

  assign a_d = '{rs1: in_rs1, shamt: dec_shamt, stype: dec_type,
                 illegal: dec_illegal, tag: in_tag};

  // Bubble-collapsing handshake: each stage can take new data when it is empty or
  // its current occupant moves on this cycle. out_ready -> in_ready is the only
  // combinational input-to-output path.
  assign b_free   = !b_valid || out_ready;
  assign a_adv    = a_valid && b_free;
  assign in_ready = !a_valid || b_free;
  assign accept   = in_valid && in_ready && !flush;

  assign shift_result = shift_apply(a_q.rs1, a_q.shamt, a_q.stype);

  // Stage A: issue register; flush wins over accept, accept wins over draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      a_valid <= 1'b0;
      // NOTE: payload is reset too so the shifter never sees X after reset.
      a_q     <= '0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_q     <= a_d;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  // Stage B: result register; holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_valid  <= 1'b0;
      b_result <= '0;
      b_tag    <= '0;
      b_err    <= 1'b0;
    end else if (flush) begin
      b_valid <= 1'b0;
    end else if (a_adv) begin
      b_valid  <= 1'b1;
      b_result <= shift_result;
      b_tag    <= a_q.tag;
      b_err    <= a_q.illegal;
    end else if (out_ready) begin
      b_valid <= 1'b0;
    end
  end

  assign out_valid  = b_valid;
  assign out_result = b_result;
  assign out_tag    = b_tag;
  assign out_err    = b_err;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Self-checking bench for shift_exec_pipe: expected results are queued when an op
// is accepted and compared in order when the pipe hands a result to the consumer.
module tb_shift_exec_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_imm = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_err;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_res = '0;
  logic [4:0]  hold_tag = '0;
  logic        hold_err = 1'b0;
  logic        last_accept = 1'b0;

  shift_exec_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour of one op, written from the instruction encoding.
  function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] rs1,
                                 input logic [31:0] rs2, input logic [4:0] imm,
                                 input logic [4:0] tag);
    exp_t e;
    logic [4:0] sh;
    logic is_shift_opc;
    is_shift_opc = (opc == 7'h33) || (opc == 7'h13);
    sh = (opc == 7'h33) ? rs2[4:0] : imm;
    e.tag = tag;
    e.result = 32'h0;
    e.err = 1'b0;
`ifdef SHIFT_EXEC_ILLEGAL_CHECK_EN
    e.err = 1'b1;
    if (is_shift_opc && f3 == 3'd1 && f7 == 7'h00) begin
      e.result = rs1 << sh;
      e.err = 1'b0;
    end else if (is_shift_opc && f3 == 3'd5 && f7 == 7'h00) begin
      e.result = rs1 >> sh;
      e.err = 1'b0;
    end else if (is_shift_opc && f3 == 3'd5 && f7 == 7'h20) begin
      e.result = 32'($signed(rs1) >>> sh);
      e.err = 1'b0;
    end
`else
    if (is_shift_opc && f3 == 3'd1) begin
      e.result = rs1 << sh;
    end else if (is_shift_opc && f3 == 3'd5) begin
      if (f7[5]) e.result = 32'($signed(rs1) >>> sh);
      else       e.result = rs1 >> sh;
    end
`endif
    return e;
  endfunction

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] imm, input logic [4:0] tag);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
    in_tag    = tag;
  endtask

  // One clock: sample just after the inputs settle, score transfers, then advance.
  task automatic cycle();
    exp_t e;
    #1;
    if (rst_n && hold_chk) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== hold_res || out_tag !== hold_tag ||
          out_err !== hold_err) begin
        n_fail++;
        $display("FAIL hold_stable: got v=%b r=%h t=%0d e=%b, want v=1 r=%h t=%0d e=%b",
                 out_valid, out_result, out_tag, out_err, hold_res, hold_tag, hold_err);
      end
    end
    hold_chk = rst_n && !flush && (out_valid === 1'b1) && !out_ready;
    hold_res = out_result;
    hold_tag = out_tag;
    hold_err = out_err;
    if (rst_n && out_valid === 1'b1 && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got r=%h t=%0d, want no output", out_result, out_tag);
      end else begin
        e = sb.pop_front();
        if (out_result !== e.result || out_tag !== e.tag || out_err !== e.err) begin
          n_fail++;
          $display("FAIL scoreboard: got r=%h t=%0d e=%b, want r=%h t=%0d e=%b",
                   out_result, out_tag, out_err, e.result, e.tag, e.err);
        end
      end
    end
    last_accept = rst_n && !flush && in_valid && (in_ready === 1'b1);
    if (last_accept)
      sb.push_back(model(in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_imm, in_tag));
    if (!rst_n || flush) sb.delete();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12 && (sb.size() > 0 || out_valid === 1'b1); i++) cycle();
    n_checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, out_valid=%b, want 0 pending, out_valid=0",
               sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cycle();
    cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_out_result: got %h want 0", out_result); end
    n_checks++;
    if (out_tag !== 5'd0) begin n_fail++; $display("FAIL reset_out_tag: got %0d want 0", out_tag); end
    n_checks++;
    if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL empty_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_sll();
    out_ready = 1'b1;
    set_op(7'h33, 3'd1, 7'h00, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd3);
    cycle();
    n_checks++;
    if (last_accept !== 1'b1) begin n_fail++; $display("FAIL sll_accept: got %b want 1", last_accept); end
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sll_latency_early: got out_valid=%b want 0", out_valid); end
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_tag !== 5'd3) begin
      n_fail++;
      $display("FAIL sll_result: got v=%b r=%h t=%0d want v=1 r=80000000 t=3", out_valid, out_result, out_tag);
    end
    drain();
  endtask

  task automatic test_srai_srli();
    out_ready = 1'b1;
    set_op(7'h13, 3'd5, 7'h20, 32'h8000_0000, 32'h0, 5'd4, 5'd5);
    cycle();
    set_op(7'h13, 3'd5, 7'h00, 32'h8000_0000, 32'h0, 5'd4, 5'd6);
    cycle();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL srai_result: got v=%b r=%h want v=1 r=f8000000", out_valid, out_result);
    end
    cycle();
    n_checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0800_0000) begin
      n_fail++;
      $display("FAIL srli_result: got v=%b r=%h want v=1 r=08000000", out_valid, out_result);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    for (int cyc = 0; cyc < 30 && (idx < 4 || sb.size() > 0); cyc++) begin
      case (idx)
        0: set_op(7'h33, 3'd1, 7'h00, 32'h1234_5678, 32'hABCD_0004, 5'd0, 5'd1);
        1: set_op(7'h13, 3'd5, 7'h00, 32'hDEAD_BEEF, 32'h0, 5'd8, 5'd2);
        2: set_op(7'h33, 3'd5, 7'h20, 32'hF000_0000, 32'h0000_0003, 5'd0, 5'd3);
        3: set_op(7'h13, 3'd1, 7'h00, 32'hCAFE_F00D, 32'h0, 5'd0, 5'd4);
        default: in_valid = 1'b0;
      endcase
      out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: cyc %0d got %b want 0", cyc, in_ready); end
      end
      if (cyc == 5) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
      end
      cycle();
      if (last_accept) idx++;
    end
    n_checks++;
    if (idx != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_complete: got %0d accepted %0d pending, want 4 accepted 0 pending", idx, sb.size());
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    set_op(7'h33, 3'd1, 7'h00, 32'h0000_00FF, 32'h0000_0004, 5'd0, 5'd10);
    cycle();
    set_op(7'h13, 3'd5, 7'h00, 32'h0000_FF00, 32'h0, 5'd4, 5'd11);
    cycle();
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_full: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
    end
    flush = 1'b1;
    set_op(7'h33, 3'd1, 7'h00, 32'h0000_0001, 32'h0000_0001, 5'd0, 5'd12);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    set_op(7'h33, 3'd5, 7'h20, 32'h8000_0001, 32'h0000_0001, 5'd0, 5'd9);
    cycle();
    drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    set_op(7'h33, 3'd1, 7'h20, 32'h0000_0001, 32'h0000_0005, 5'd0, 5'd7);
    cycle();
    set_op(7'h33, 3'd0, 7'h00, 32'h0000_0003, 32'h0000_0001, 5'd0, 5'd8);
    cycle();
    in_valid = 1'b0;
`ifdef SHIFT_EXEC_ILLEGAL_CHECK_EN
    n_checks++;
    if (out_result !== 32'h0 || out_err !== 1'b1 || out_tag !== 5'd7) begin
      n_fail++;
      $display("FAIL illegal_f7: got r=%h e=%b t=%0d want r=0 e=1 t=7", out_result, out_err, out_tag);
    end
`else
    n_checks++;
    if (out_result !== 32'h0000_0020 || out_err !== 1'b0 || out_tag !== 5'd7) begin
      n_fail++;
      $display("FAIL illegal_f7: got r=%h e=%b t=%0d want r=20 e=0 t=7", out_result, out_err, out_tag);
    end
`endif
    cycle();
    n_checks++;
    if (out_result !== 32'h0 || out_tag !== 5'd8) begin
      n_fail++;
      $display("FAIL non_shift_result: got r=%h t=%0d want r=0 t=8", out_result, out_tag);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_op(7'h33, 3'd1, 7'h00, 32'h0000_0011, 32'h0000_0002, 5'd0, 5'd13);
    cycle();
    set_op(7'h33, 3'd1, 7'h00, 32'h0000_0022, 32'h0000_0002, 5'd0, 5'd14);
    cycle();
    rst_n = 1'b0;
    cycle();
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'd0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got v=%b r=%h t=%0d e=%b want all 0",
               out_valid, out_result, out_tag, out_err);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stale_after_reset: cyc %0d got out_valid=%b want 0", i, out_valid); end
    end
    set_op(7'h13, 3'd1, 7'h00, 32'h0000_0005, 32'h0, 5'd3, 5'd15);
    cycle();
    drain();
  endtask

  task automatic test_throughput();
    int r;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 2);
      set_op(($urandom_range(0, 1) == 0) ? 7'h33 : 7'h13,
             (r == 0) ? 3'd1 : 3'd5,
             (r == 2) ? 7'h20 : 7'h00,
             $urandom, $urandom, 5'($urandom_range(0, 31)), 5'(i));
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL throughput_in_ready: op %0d got %b want 1", i, in_ready); end
      cycle();
    end
    drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sll();
    test_srai_srli();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_throughput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
